// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage types, payload widths and pack/unpack helpers
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [31:0] pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [3:0]  dest;
        logic [3:0]  sr;
    } id_exe_t;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [3:0]  dest;
    } exe_mem_t;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] result;
        logic [3:0]  dest;
    } mem_wb_t;

    localparam int ID_EXE_W  = $bits(id_exe_t);
    localparam int EXE_MEM_W = $bits(exe_mem_t);
    localparam int MEM_WB_W  = $bits(mem_wb_t);

    function automatic logic [ID_EXE_W-1:0] pack_id_exe(input id_exe_t p);
        return p;
    endfunction

    function automatic id_exe_t unpack_id_exe(input logic [ID_EXE_W-1:0] d);
        return id_exe_t'(d);
    endfunction

    function automatic logic [EXE_MEM_W-1:0] pack_exe_mem(input exe_mem_t p);
        return p;
    endfunction

    function automatic exe_mem_t unpack_exe_mem(input logic [EXE_MEM_W-1:0] d);
        return exe_mem_t'(d);
    endfunction

    function automatic logic [MEM_WB_W-1:0] pack_mem_wb(input mem_wb_t p);
        return p;
    endfunction

    function automatic mem_wb_t unpack_mem_wb(input logic [MEM_WB_W-1:0] d);
        return mem_wb_t'(d);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised valid/ready pipeline stage register with optional skid buffer
//
// Ports:
//   clk, rst (async, active-high)   clock and reset
//   flush                           synchronous squash of all held entries
//   in_valid/in_ready/in_data       upstream handshake and payload
//   out_valid/out_ready/out_data    downstream handshake and payload
//   occupancy                       number of held entries (0..2)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int SKID           = 1,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_state_t       state_q;
    logic [DATA_W-1:0] m_q;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = m_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            BUSY:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] k_q;
            logic              rdy_q;

            // in_ready is a flop so a stall never ripples combinationally upstream;
            // the second entry lands in K while the stage is stalled.
            assign in_ready = rdy_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= EMPTY;
                    m_q     <= '0;
                    k_q     <= '0;
                    rdy_q   <= 1'b1;
                end else if (flush) begin
                    state_q <= EMPTY;
                    rdy_q   <= 1'b1;
                    if (CLEAR_ON_FLUSH != 0) begin
                        m_q <= '0;
                        k_q <= '0;
                    end
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (in_fire) begin
                                state_q <= BUSY;
                                m_q     <= in_data;
                            end
                        end
                        BUSY: begin
                            if (in_fire && out_fire) begin
                                m_q <= in_data;
                            end else if (in_fire) begin
                                state_q <= FULL;
                                k_q     <= in_data;
                                rdy_q   <= 1'b0;
                            end else if (out_fire) begin
                                state_q <= EMPTY;
                            end
                        end
                        FULL: begin
                            if (out_fire) begin
                                state_q <= BUSY;
                                m_q     <= k_q;
                                rdy_q   <= 1'b1;
                            end
                        end
                        default: begin
                            state_q <= EMPTY;
                            rdy_q   <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_noskid
            // Single register: accept whenever the held entry leaves this cycle.
            assign in_ready = ~out_valid | out_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= EMPTY;
                    m_q     <= '0;
                end else if (flush) begin
                    state_q <= EMPTY;
                    if (CLEAR_ON_FLUSH != 0) begin
                        m_q <= '0;
                    end
                end else if (in_fire) begin
                    state_q <= BUSY;
                    m_q     <= in_data;
                end else if (out_fire) begin
                    state_q <= EMPTY;
                end
            end
        end
    endgenerate

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline stage register. It is the next generation of the per-stage IF/ID/EXE/MEM registers in the ARM core.
- Carries an opaque packed payload (control bits, PC, operands, dest/src tags, SR) between stages with a valid/ready handshake.
- Supports stall via backpressure, synchronous flush (branch squash) and an optional 2-entry skid buffer. The skid buffer registers in_ready so stall paths do not chain combinationally across stages.
- Adjacent stages pack and unpack the payload.

Parameters:
- DATA_W, 32: payload width in bits; legal range 1..512.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CLEAR_ON_FLUSH, 1: 1 = payload registers are zeroed on flush; 0 = payload is held and only valid is cleared.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream accepts the entry (0 = stall).
- out_data  out  DATA_W  payload presented downstream.
- occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Transfer rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (asynchronous):
  - state = EMPTY; out_valid = 0; out_data = 0; skid register = 0; occupancy = 0; in_ready = 1.
  - Reset asserted mid-transfer discards all held entries.
- Flush has highest synchronous priority:
  - Next state = EMPTY; out_valid = 0; occupancy = 0.
  - Payload and skid register go to 0 if CLEAR_ON_FLUSH=1, otherwise they hold their values.
  - An in_fire in the flush cycle is dropped.
  - An out_fire in the flush cycle completes downstream; the stage only guarantees it is not re-presented.
- SKID=1 state machine (main register M, skid register K):
  - EMPTY: in_fire -> BUSY, M <= in_data.
  - BUSY:
    - in_fire & out_fire -> BUSY, M <= in_data.
    - in_fire & !out_fire -> FULL, K <= in_data.
    - !in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - FULL: out_fire -> BUSY, M <= K; otherwise hold. in_ready is 0, so in_data is ignored.
  - in_ready is a flop: next value is 1 unless the next state is FULL.
  - out_valid = (state != EMPTY); out_data = M.
  - occupancy: EMPTY = 0, BUSY = 1, FULL = 2.
- SKID=0 mode:
  - States EMPTY and BUSY only.
  - in_ready = !out_valid | out_ready (combinational from out_ready).
  - in_fire loads M; out_fire without in_fire -> EMPTY.
  - occupancy never exceeds 1.
- Latency and throughput:
  - in_fire at edge N gives out_valid=1 with that data after edge N.
  - Sustained throughput is 1 entry/cycle when out_ready=1.
- Payload rules: the payload is never modified. Order is strictly FIFO and no entry is duplicated or lost, except through flush or rst.
- Stall: out_data and out_valid stay stable while out_valid & !out_ready.
- in_data must not be sampled when in_ready=0. An in_valid asserted while in_ready=0 is held by upstream.

Decomposition:
- Shared package pipe_pkg:
  - state enum EMPTY/BUSY/FULL.
  - Per-stage payload width constants: ID_EXE_W, EXE_MEM_W, MEM_WB_W.
  - Pack/unpack functions for each stage payload, so the core instantiates pipe_stage_reg #(.DATA_W(pipe_pkg::ID_EXE_W)).
- No sub-module. The skid register is inline and gated by a generate on SKID.

Test Plan (DATA_W=8):
1. Streaming, SKID=1, out_ready=1: feed 0x01..0x05 back-to-back. Expect out_data 0x01..0x05 on consecutive cycles, 1 cycle latency, occupancy stays 1.
2. Stall and skid:
   - Hold 0x11 in BUSY, drop out_ready, present 0x22. Expect FULL, occupancy=2, in_ready=0 next cycle.
   - Raise out_ready. Expect 0x11 then 0x22 with nothing lost, and in_ready returns to 1 after the first out_fire.
3. Flush while FULL (0x33, 0x44 held) with in_valid=1 and 0x55 present:
   - Next cycle out_valid=0, occupancy=0, out_data=0x00 (CLEAR_ON_FLUSH=1); 0x55 is not output.
   - Repeat with CLEAR_ON_FLUSH=0: out_data=0x33 and out_valid=0.
4. Asynchronous reset mid-stream: assert rst between edges while BUSY with 0x66. Expect out_valid=0, out_data=0x00 and in_ready=1 immediately; after release, 0x77 propagates normally.
5. SKID=0: out_ready=0 while BUSY. Expect in_ready=0 in the same cycle (combinational). Raising out_ready with in_valid=1 (0x88) gives a simultaneous pass-through replacement the next cycle.
6. Random valid/ready soak, 10k cycles, both SKID values: scoreboard shows FIFO order and no loss or duplication, and out_data is stable during every stall.
